// File: rtl/definitions.sv
// Shared core definitions: data word and divider types.
// Imported by execute-stage units.
package definitions;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] t_data;

  typedef enum logic [1:0] {
    DIV_OP_DIV,
    DIV_OP_DIVU,
    DIV_OP_REM,
    DIV_OP_REMU
  } t_div_operation;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_DONE
  } t_divider_state;

  function automatic logic is_rem_op(input t_div_operation o);
    return (o == DIV_OP_REM) || (o == DIV_OP_REMU);
  endfunction

  function automatic logic is_signed_op(input t_div_operation o);
    return (o == DIV_OP_DIV) || (o == DIV_OP_REM);
  endfunction

endpackage

// File: rtl/divider.sv
// Iterative RV32M divider: one restoring step per cycle.
// Start/done handshake; core stalls while busy.
module divider
  import definitions::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_start,
  input  t_div_operation i_operation,
  input  t_data          i_operand1,
  input  t_data          i_operand2,
  output logic           o_ready,
  output logic           o_done,
  output t_data          o_result
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam int W  = DATA_WIDTH;

  typedef logic [W-1:0] t_word;

  function automatic t_word negate(
    input t_word v,
    input logic  en
  );
    return en ? (~v + 1'b1) : v;
  endfunction

  t_divider_state state;
  t_divider_state state_next;

  logic [CW-1:0]  count;
  t_div_operation op;
  logic           neg_q;
  logic           neg_r;
  t_word          quo;
  t_word          rem;
  t_word          div_b;

  logic           in_signed;
  logic           a_neg;
  logic           b_neg;
  logic           div_zero;
  logic           overflow;
  logic           special;
  t_word          abs_a;
  t_word          abs_b;
  t_word          spec_q;
  t_word          spec_r;

  logic [W:0]     rem_sh;
  logic [W:0]     diff;
  logic           fits;
  t_word          quo_step;
  t_word          rem_step;
  t_word          res_q;
  t_word          res_r;

  assign o_ready = (state == DIV_IDLE);
  assign o_done  = (state == DIV_DONE);

  // Operand conditioning and RISC-V special-case detection.
  always_comb begin
    in_signed = is_signed_op(i_operation);
    a_neg     = in_signed & i_operand1[W-1];
    b_neg     = in_signed & i_operand2[W-1];
    abs_a     = negate(i_operand1, a_neg);
    abs_b     = negate(i_operand2, b_neg);
    div_zero  = (i_operand2 == '0);
    overflow  = in_signed
              && (i_operand1 == {1'b1, {(W-1){1'b0}}})
              && (i_operand2 == '1);
    special   = div_zero | overflow;
    spec_q    = div_zero ? '1 : {1'b1, {(W-1){1'b0}}};
    spec_r    = div_zero ? i_operand1 : '0;
  end

  // One restoring step plus final sign fix-up.
  always_comb begin
    rem_sh   = {rem, quo[W-1]};
    diff     = rem_sh - {1'b0, div_b};
    fits     = ~diff[W];
    rem_step = fits ? diff[W-1:0] : rem_sh[W-1:0];
    quo_step = {quo[W-2:0], fits};
    res_q    = negate(quo_step, neg_q);
    res_r    = negate(rem_step, neg_r);
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      DIV_IDLE: begin
        if (i_start) begin
          state_next = special ? DIV_DONE : DIV_CALC;
        end
      end
      DIV_CALC: begin
        if (count == '0) begin
          state_next = DIV_DONE;
        end
      end
      DIV_DONE: begin
        state_next = DIV_IDLE;
      end
      default: begin
        state_next = DIV_IDLE;
      end
    endcase
  end

  // State, counter, datapath and result registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= DIV_IDLE;
      count    <= '0;
      op       <= DIV_OP_DIV;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      div_b    <= '0;
      o_result <= '0;
    end else begin
      state <= state_next;
      case (state)
        DIV_IDLE: begin
          if (i_start) begin
            op    <= i_operation;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            quo   <= abs_a;
            rem   <= '0;
            div_b <= abs_b;
            count <= CW'(W - 1);
            if (special) begin
              o_result <= is_rem_op(i_operation)
                        ? spec_r : spec_q;
            end
          end
        end
        DIV_CALC: begin
          quo <= quo_step;
          rem <= rem_step;
          if (count != '0) begin
            count <= count - 1'b1;
          end else begin
            o_result <= is_rem_op(op) ? res_r : res_q;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/divider.md
# divider

Iterative RV32M division unit executing DIV, DIVU, REM and REMU over multiple cycles with a start/done handshake. It sits in the execute stage next to the single-cycle `alu`. It receives the same two `t_data` operands and returns one `t_data` result. The core stalls while the unit is busy.

## Interface
Parameters:
- `DATA_WIDTH`, 32: operand and result width. It must match `t_data`. Iteration count equals `DATA_WIDTH`.

Ports:
- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_reset`  in  1  reset, asynchronous and active-high.
- `i_start`  in  1  request a division; accepted only when `o_ready` = 1.
- `i_operation`  in  `t_div_operation`  DIV, DIVU, REM or REMU; sampled on acceptance.
- `i_operand1`  in  `t_data`  dividend; sampled on acceptance.
- `i_operand2`  in  `t_data`  divisor; sampled on acceptance.
- `o_ready`  out  1  high in IDLE only.
- `o_done`  out  1  one-cycle pulse; `o_result` is valid in this cycle.
- `o_result`  out  `t_data`  quotient or remainder. It holds its value until the next `o_done`.

## Operation
States and transitions:
- **IDLE:**
  - Moves on `i_start`.
  - Special case present → DONE.
  - Otherwise → CALC with counter = `DATA_WIDTH`-1.
- **CALC:**
  - One restoring step per cycle.
  - Leaves when counter = 0 → DONE.
- **DONE:**
  - `o_done` = 1; final sign fix-up is already applied to `o_result`.
  - → IDLE unconditionally.

Datapath:
- On acceptance, latch `op`, `neg_q`, `neg_r` and the magnitudes |a| and |b|.
- Signed ops (DIV, REM) use two's-complement absolute value. The magnitude of 0x80000000 is 0x80000000 treated as unsigned.
- Unsigned ops pass the operands through unchanged.
- Restoring step:
  - `{rem, quo}` is shifted left by 1.
  - If `rem_shifted` ≥ `b`, then `rem` = `rem_shifted` − `b` and `quo[0]` = 1.
  - Comparison and subtraction are `DATA_WIDTH`+1 bits wide to avoid overflow.
- Signs:
  - `neg_q` = `a[31]` ^ `b[31]` (signed op).
  - `neg_r` = `a[31]` (signed op).
  - The result is negated when the corresponding flag is set.
- Result selection: DIV and DIVU return the quotient; REM and REMU return the remainder.

Special cases (RISC-V defined, no trap):
- Divisor 0: quotient = 0xFFFFFFFF for both DIV and DIVU; remainder = dividend.
- DIV/REM with 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0.

Other rules:
- `i_start` while not ready is ignored; no queueing and no effect on the running operation.
- Operand and operation inputs may change freely after acceptance.

## Timing
- Reset values: state = IDLE, `o_ready` = 1, `o_done` = 0, `o_result` = 0, counter = 0.
- Latency, with start accepted on edge N:
  - Normal operation: `o_done` high in the cycle after edge N+`DATA_WIDTH`+1, i.e. 33 cycles of busy for 32-bit data.
  - Special cases: `o_done` high in the cycle after edge N+1 (1 cycle busy).
- `o_ready` falls in the cycle after acceptance and returns in the cycle after DONE.
  - `i_start` held continuously therefore starts a new operation every 34 cycles.
  - A back-to-back start in the DONE cycle is not accepted.
- `o_result` changes only on the edge entering DONE, or on reset.
- Reset asserted mid-operation aborts immediately to reset values. No `o_done` is produced for the aborted request.

## Structure
- Add to the `definitions` package:
  - `typedef enum` `t_div_operation` {`DIV_OP_DIV`, `DIV_OP_DIVU`, `DIV_OP_REM`, `DIV_OP_REMU`}.
  - `t_divider_state` {`DIV_IDLE`, `DIV_CALC`, `DIV_DONE`}.
- `t_data` is reused from `definitions`.
- Single module; no sub-module is warranted. The step logic is one subtractor plus a mux. Sign fix-up shares one negation function.
- Control is split into a sequential `always_ff` (state, counter, registers) and an `always_comb` next-state/step block.

## Test plan
- DIVU 100 / 7 → `o_result` = 14, `o_done` 33 cycles after the start edge; REMU 100 / 7 → 2.
- DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD (−3); REM → 0xFFFFFFFF (−1); REM 7 / −2 → 1.
- DIVU 5 / 0 → 0xFFFFFFFF; REMU 5 / 0 → 5; DIV −5 / 0 → 0xFFFFFFFF. Each `o_done` arrives 1 cycle after start.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0. DIVU of the same operands → 0, normal 33-cycle latency.
- `i_start` pulsed with different operands at cycle 10 of a running DIVU 100/7 → ignored. Result is still 14, and exactly one `o_done` is produced.
- `i_reset` asserted at cycle 15 of a DIVU → `o_ready` = 1, `o_result` = 0 immediately, and no `o_done`. A following DIVU 9/3 → 3.
